// File: rtl/cont_cresc.sv
// cont_cresc: two-digit BCD elapsed-time up-counter with IDLE/RUN/FIN control.
// Stops at a clamped, latched target and pulses Done_pulse on entry to FIN.
module cont_cresc #(
    parameter int MAX_DEZ = 9
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Tick,
    input  logic [3:0] Target_Dez,
    input  logic [3:0] Target_Uni,
    output logic [3:0] Dez,
    output logic [3:0] Uni,
    output logic       Running,
    output logic       Done,
    output logic       Done_pulse
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam logic [3:0] MD = 4'(MAX_DEZ);
    state_t     state, state_nx;
    logic [3:0] tgt_dez, tgt_uni, tgt_dez_nx, tgt_uni_nx;
    logic [3:0] dez_nx, uni_nx, cl_dez, cl_uni, inc_dez, inc_uni;
    logic       pulse_nx;
    assign cl_dez  = (Target_Dez > MD) ? MD : Target_Dez;
    assign cl_uni  = (Target_Uni > 4'd9) ? 4'd9 : Target_Uni;
    assign inc_uni = (Uni == 4'd9) ? 4'd0 : Uni + 4'd1;
    assign inc_dez = (Uni == 4'd9) ? Dez + 4'd1 : Dez;
    assign Running = (state == RUN);
    assign Done    = (state == FIN);
    // Stop outranks Start, which outranks Tick; Tick only counts in RUN.
    always_comb begin
        state_nx   = state;
        dez_nx     = Dez;
        uni_nx     = Uni;
        tgt_dez_nx = tgt_dez;
        tgt_uni_nx = tgt_uni;
        pulse_nx   = 1'b0;
        if (Stop) begin
            state_nx = IDLE;
        end else if (Start) begin
            dez_nx     = 4'd0;
            uni_nx     = 4'd0;
            tgt_dez_nx = cl_dez;
            tgt_uni_nx = cl_uni;
            pulse_nx   = (cl_dez == 4'd0) && (cl_uni == 4'd0);
            state_nx   = pulse_nx ? FIN : RUN;
        end else if (Tick && state == RUN) begin
            dez_nx   = inc_dez;
            uni_nx   = inc_uni;
            pulse_nx = (inc_dez == tgt_dez) && (inc_uni == tgt_uni);
            state_nx = pulse_nx ? FIN : RUN;
        end
    end
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            Dez        <= 4'd0;
            Uni        <= 4'd0;
            tgt_dez    <= 4'd0;
            tgt_uni    <= 4'd0;
            Done_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            Dez        <= dez_nx;
            Uni        <= uni_nx;
            tgt_dez    <= tgt_dez_nx;
            tgt_uni    <= tgt_uni_nx;
            Done_pulse <= pulse_nx;
        end
    end
endmodule
